// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier: operands reduced to magnitudes, one partial product
// per cycle, early exit once the remaining multiplier bits are zero, sign applied on completion.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Handshake: start is accepted only when the block is idle (busy=0, done=0); done is a
  // one-cycle pulse during which product is valid, and product then holds until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_q, sign_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum;

  always_comb begin
    // The most negative value negates to itself, which read as unsigned is its magnitude.
    a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          if (b_mag == '0) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Exit as soon as no set multiplier bits remain above the one just consumed.
        if (mplier_q[WIDTH-1:1] == '0) begin
          state_d   = DONE;
          product_d = sign_q ? -acc_sum : acc_sum;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
    end
  end

  // busy and done together expose the state: 00 idle, 10 calculating, 01 done.
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul at WIDTH 8, 16 and 32: directed table, hand-written corner sequences and
// random jobs scored against an arithmetic reference multiply and cycle-count rule.
module tb_seq_mul;

  logic clk;
  logic rst_n;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );
  seq_mul dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );
  seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input int w);
    case (w)
      8:       return done8;
      32:      return done32;
      default: return done16;
    endcase
  endfunction

  function automatic logic cur_busy(input int w);
    case (w)
      8:       return busy8;
      32:      return busy32;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [63:0] cur_prod(input int w);
    case (w)
      8:       return {48'd0, prod8};
      32:      return prod32;
      default: return {32'd0, prod16};
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic sm,
                       input logic [63:0] av, input logic [63:0] bv);
    case (w)
      8:       begin start8  = st; sm8  = sm; a8  = av[7:0];  b8  = bv[7:0];  end
      32:      begin start32 = st; sm32 = sm; a32 = av[31:0]; b32 = bv[31:0]; end
      default: begin start16 = st; sm16 = sm; a16 = av[15:0]; b16 = bv[15:0]; end
    endcase
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // ---------------- reference model ----------------
  function automatic longint sext(input logic [63:0] v, input int w);
    longint r;
    r = longint'(v & wmask(w));
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                          input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] r, m;
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (sm) r = 64'(sext(av, w) * sext(bv, w));
    else    r = (av & wmask(w)) * (bv & wmask(w));
    return r & m;
  endfunction

  // Number of calculation cycles: bit length of the multiplier magnitude.
  function automatic int ref_cycles(input int w, input logic sm, input logic [63:0] bv);
    logic [63:0] mag;
    int n;
    mag = bv & wmask(w);
    if (sm && bv[w-1]) mag = (64'd1 << w) - mag;
    n = 0;
    while (mag != 0) begin
      n++;
      mag = mag >> 1;
    end
    return n;
  endfunction

  // ---------------- job driver ----------------
  task automatic run_job(input int w, input logic sm, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] prod, output int lat, output int bcnt,
                         output int proto_err);
    logic [63:0] prev;
    @(negedge clk);
    drive(w, 1'b1, sm, av, bv);
    prev = cur_prod(w);
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; they must have no effect.
    drive(w, 1'b0, ~sm, {$urandom, $urandom}, {$urandom, $urandom});
    lat = 1;
    bcnt = 0;
    proto_err = 0;
    while (!cur_done(w) && lat < 80) begin
      if (cur_busy(w)) bcnt++;
      if (cur_prod(w) !== prev) proto_err++;
      @(posedge clk);
      #1;
      lat++;
    end
    prod = cur_prod(w);
    if (cur_busy(w)) proto_err++;
    @(posedge clk);
    #1;
    if (cur_done(w) || cur_busy(w)) proto_err++;
    if (cur_prod(w) !== prod) proto_err++;
  endtask

  task automatic check_job(input string name, input int w, input logic sm,
                           input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] prod;
    int lat, bcnt, perr, n;
    exp_q.push_back(ref_mul(w, sm, av, bv));
    n = ref_cycles(w, sm, bv);
    run_job(w, sm, av, bv, prod, lat, bcnt, perr);
    chk({name, " product"}, prod, exp_q.pop_front());
    chk({name, " latency"}, 64'(lat), 64'(n + 1));
    chk({name, " busy_cycles"}, 64'(bcnt), 64'(n));
    chk({name, " protocol"}, 64'(perr), 64'd0);
  endtask

  // ---------------- directed table (WIDTH=16) ----------------
  typedef struct {
    string       name;
    logic        sm;
    logic [15:0] av;
    logic [15:0] bv;
    logic [31:0] exp_prod;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] prod;
    int lat, bcnt, perr, k, k1, k2;
    logic [63:0] p1, p2;

    vecs[0] = '{"u7x5",         1'b0, 16'h0007, 16'h0005, 32'h0000_0023, 3};
    vecs[1] = '{"b_zero",       1'b0, 16'h1234, 16'h0000, 32'h0000_0000, 0};
    vecs[2] = '{"s_m3x4",       1'b1, 16'hFFFD, 16'h0004, 32'hFFFF_FFF4, 3};
    vecs[3] = '{"u_max",        1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16};
    vecs[4] = '{"s_min_sq",     1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 16};
    vecs[5] = '{"s_m1xm1",      1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1};

    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy16), 64'd0);
    chk("reset done", 64'(done16), 64'd0);
    chk("reset product", cur_prod(16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(16, vecs[i].sm, 64'(vecs[i].av), 64'(vecs[i].bv), prod, lat, bcnt, perr);
      chk({vecs[i].name, " product"}, prod, 64'(vecs[i].exp_prod));
      chk({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].exp_n + 1));
      chk({vecs[i].name, " busy_cycles"}, 64'(bcnt), 64'(vecs[i].exp_n));
      chk({vecs[i].name, " protocol"}, 64'(perr), 64'd0);
    end

    // start pulsed with other operands throughout CALC must not disturb the running job
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'h7, 64'hFF);
    @(posedge clk);
    #1;
    lat = 1;
    while (!done16 && lat < 40) begin
      drive(16, 1'b1, 1'b1, 64'h1111, 64'h2);
      @(posedge clk);
      #1;
      lat++;
    end
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("ignore_start product", cur_prod(16), 64'h6F9);
    chk("ignore_start latency", 64'(lat), 64'd9);
    @(posedge clk);
    #1;
    chk("ignore_start no_restart", 64'(busy16 | done16), 64'd0);

    // start held high: second job accepted in the idle cycle following DONE
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'd5, 64'd3);
    k1 = 0; k2 = 0; p1 = '0; p2 = '0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) drive(16, 1'b1, 1'b0, 64'd9, 64'd6);
      if (k == 5) drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
      if (done16 && k1 == 0) begin
        k1 = k;
        p1 = cur_prod(16);
      end else if (done16 && k2 == 0) begin
        k2 = k;
        p2 = cur_prod(16);
      end
    end
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("b2b first_done_edge", 64'(k1), 64'd3);
    chk("b2b first_product", p1, 64'd15);
    chk("b2b second_done_edge", 64'(k2), 64'd8);
    chk("b2b second_product", p2, 64'd54);

    // reset during the second CALC cycle aborts the job
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'd7, 64'hFF);
    @(posedge clk);
    #1;
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy16), 64'd0);
    chk("abort done", 64'(done16), 64'd0);
    chk("abort product", cur_prod(16), 64'd0);
    k = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done16 || busy16) k++;
    end
    chk("abort no_done", 64'(k), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_job("post_reset", 16, 1'b1, 64'hFFF9, 64'h0006);

    // randomized jobs, biased toward small and zero multipliers now and then
    for (int i = 0; i < 300; i++) begin
      logic [63:0] av, bv;
      av = {$urandom, $urandom} & wmask(16);
      bv = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 3)) : ({$urandom, $urandom} & wmask(16));
      check_job("rand16", 16, 1'($urandom_range(0, 1)), av, bv);
    end
    for (int i = 0; i < 800; i++) begin
      logic [63:0] av, bv;
      av = {$urandom, $urandom} & wmask(8);
      bv = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 3)) : ({$urandom, $urandom} & wmask(8));
      check_job("rand8", 8, 1'($urandom_range(0, 1)), av, bv);
    end
    check_job("w32_min_sq", 32, 1'b1, 64'h8000_0000, 64'h8000_0000);
    check_job("w32_umax", 32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    for (int i = 0; i < 700; i++) begin
      logic [63:0] av, bv;
      av = {$urandom, $urandom} & wmask(32);
      bv = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 3)) : ({$urandom, $urandom} & wmask(32));
      check_job("rand32", 32, 1'($urandom_range(0, 1)), av, bv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
